// File: rtl/booth_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : booth_mac_seq
// Purpose  : Sequencer and accumulator wrapped around a sequential Booth
//            multiplier. Accepts signed operand pairs over a valid/ready
//            stream, issues each pair to the multiplier, waits for it to
//            finish, sign-extends the 2W-bit product into a guarded
//            accumulator, and presents the dot-product once the pair tagged
//            in_last has been accumulated.
// Ports    : clk, rst                    - clock, synchronous active-high reset
//            in_valid/in_ready           - operand stream handshake
//            in_x, in_y, in_last         - signed operands, end-of-sum tag
//            mul_x, mul_y, mul_start     - registered operands and start pulse
//            mul_busy, mul_z             - multiplier status and product
//            acc_valid/acc_ready         - result stream handshake
//            acc_out                     - signed sum, 2W+G bits
//            term_cnt                    - products in current sum (debug)
//            sat_flag                    - sticky clamp flag (SATURATE_EN only)
// Config   : SATURATE_EN - clamp on signed overflow instead of wrapping and
//            add the sat_flag output.
// Revision : 1.0 - initial release
// ============================================================================
module booth_mac_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int GUARD_BITS = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [DATA_WIDTH-1:0]                in_x,
    input  logic [DATA_WIDTH-1:0]                in_y,
    input  logic                                 in_last,
    output logic [DATA_WIDTH-1:0]                mul_x,
    output logic [DATA_WIDTH-1:0]                mul_y,
    output logic                                 mul_start,
    input  logic                                 mul_busy,
    input  logic [2*DATA_WIDTH-1:0]              mul_z,
    output logic                                 acc_valid,
    input  logic                                 acc_ready,
    output logic [2*DATA_WIDTH+GUARD_BITS-1:0]   acc_out,
`ifdef SATURATE_EN
    output logic [GUARD_BITS:0]                  term_cnt,
    output logic                                 sat_flag
`else
    output logic [GUARD_BITS:0]                  term_cnt
`endif
);

    localparam int ACC_W = 2 * DATA_WIDTH + GUARD_BITS;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT_HI = 3'd2,
        S_WAIT_LO = 3'd3,
        S_SETTLE  = 3'd4,
        S_OUT     = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   mul_x_q, mul_x_d;
    logic [DATA_WIDTH-1:0]   mul_y_q, mul_y_d;
    logic                    last_q,  last_d;
    logic [ACC_W-1:0]        acc_q,   acc_d;
    logic [GUARD_BITS:0]     cnt_q,   cnt_d;
    logic                    sat_q,   sat_d;

    logic [ACC_W-1:0]        w_prod_ext;
    logic [ACC_W-1:0]        w_sum;
    logic                    w_ovf;
    logic [ACC_W-1:0]        w_acc_next;
    logic                    w_clamp;

    // Product sign-extended to accumulator width before the add.
    assign w_prod_ext = {{GUARD_BITS{mul_z[2*DATA_WIDTH-1]}}, mul_z};
    assign w_sum      = acc_q + w_prod_ext;
    // Signed overflow: operands share a sign that the sum does not.
    assign w_ovf      = (acc_q[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                        (w_sum[ACC_W-1] != acc_q[ACC_W-1]);

`ifdef SATURATE_EN
    always_comb begin
        w_acc_next = w_sum;
        w_clamp    = 1'b0;
        if (w_ovf) begin
            w_clamp = 1'b1;
            // Operand sign selects the rail: negative -> most negative value.
            w_acc_next = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                        : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
    assign sat_flag = sat_q;
`else
    always_comb begin
        w_acc_next = w_sum;
        w_clamp    = w_ovf & 1'b0;
    end
`endif

    always_comb begin
        state_d = state_q;
        mul_x_d = mul_x_q;
        mul_y_d = mul_y_q;
        last_d  = last_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mul_x_d = in_x;
                    mul_y_d = in_y;
                    last_d  = in_last;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE:   state_d = S_WAIT_HI;
            // Absorbs any start-to-busy latency of the multiplier.
            S_WAIT_HI: if (mul_busy)  state_d = S_WAIT_LO;
            S_WAIT_LO: if (!mul_busy) state_d = S_SETTLE;
            S_SETTLE: begin
                acc_d   = w_acc_next;
                cnt_d   = cnt_q + 1'b1;
                sat_d   = sat_q | w_clamp;
                state_d = last_q ? S_OUT : S_IDLE;
            end
            S_OUT: begin
                if (acc_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mul_x_q <= '0;
            mul_y_q <= '0;
            last_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mul_x_q <= mul_x_d;
            mul_y_q <= mul_y_d;
            last_q  <= last_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    // Moore outputs decoded from the registered state.
    assign in_ready  = (state_q == S_IDLE);
    assign mul_start = (state_q == S_ISSUE);
    assign acc_valid = (state_q == S_OUT);
    assign mul_x     = mul_x_q;
    assign mul_y     = mul_y_q;
    assign acc_out   = acc_q;
    assign term_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_mac_seq
// Purpose  : Directed self-checking bench for booth_mac_seq with a behavioural
//            multi-cycle multiplier model (busy for 4 cycles after start).
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_mac_seq;

    localparam int W     = 16;
    localparam int G     = 4;
    localparam int ACC_W = 2 * W + G;
    localparam int BUSY_CYCLES = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       in_x, in_y;
    logic               in_last;
    logic [W-1:0]       mul_x, mul_y;
    logic               mul_start;
    logic               mul_busy;
    logic [2*W-1:0]     mul_z;
    logic               acc_valid;
    logic               acc_ready;
    logic [ACC_W-1:0]   acc_out;
    logic [G:0]         term_cnt;
`ifdef SATURATE_EN
    logic               sat_flag;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int start_cnt = 0;
    int start_run_err = 0;
    int hold_err = 0;

    always #5 clk = ~clk;

    booth_mac_seq #(.DATA_WIDTH(W), .GUARD_BITS(G)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_last   (in_last),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_start (mul_start),
        .mul_busy  (mul_busy),
        .mul_z     (mul_z),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .acc_out   (acc_out),
`ifdef SATURATE_EN
        .term_cnt  (term_cnt),
        .sat_flag  (sat_flag)
`else
        .term_cnt  (term_cnt)
`endif
    );

    // Multiplier model: busy rises the cycle after start, stays high for
    // BUSY_CYCLES cycles, product appears as busy falls.
    logic signed [W-1:0] m_px, m_py;
    int                  m_cnt;
    logic                start_prev;

    always @(posedge clk) begin
        if (rst) begin
            mul_busy <= 1'b0;
            mul_z    <= '0;
            m_cnt    <= 0;
            m_px     <= '0;
            m_py     <= '0;
        end else if (mul_start) begin
            mul_busy <= 1'b1;
            m_cnt    <= BUSY_CYCLES;
            m_px     <= mul_x;
            m_py     <= mul_y;
        end else if (mul_busy) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                mul_busy <= 1'b0;
                mul_z    <= (2*W)'(m_px * m_py);
            end
        end
    end

    // Pulse and operand-stability monitor.
    always @(posedge clk) begin
        if (rst) begin
            start_prev <= 1'b0;
        end else begin
            start_prev <= mul_start;
            if (mul_start) start_cnt <= start_cnt + 1;
            if (mul_start && start_prev) start_run_err <= start_run_err + 1;
            if (mul_busy && (mul_x !== m_px || mul_y !== m_py)) hold_err <= hold_err + 1;
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents a pair and returns #1 after the accepting edge.
    task automatic send_pair(input string tag, input int x, input int y, input logic last);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_x     = x[W-1:0];
        in_y     = y[W-1:0];
        in_last  = last;
        for (int i = 0; i < 200 && !acc; i++) begin
            acc = in_ready;
            tick(1);
        end
        in_valid = 1'b0;
        if (!acc) check({tag, "_accept_timeout"}, 0, 1);
    endtask

    task automatic wait_acc_valid(input string tag);
        for (int i = 0; i < 200 && !acc_valid; i++) tick(1);
        if (!acc_valid) check({tag, "_acc_valid_timeout"}, acc_valid, 1);
    endtask

    task automatic drain(input string tag);
        acc_ready = 1'b1;
        tick(1);
        acc_ready = 1'b0;
        check({tag, "_valid_drop"}, acc_valid, 0);
        check({tag, "_acc_clear"}, $signed(acc_out), 0);
        check({tag, "_cnt_clear"}, term_cnt, 0);
    endtask

    initial begin
        int s0;
        rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_last = 1'b0; acc_ready = 1'b0;
        tick(3);
        rst = 1'b0;

        // 1. Reset state and idle
        tick(10);
        check("idle_in_ready",  in_ready, 1);
        check("idle_acc_valid", acc_valid, 0);
        check("idle_no_start",  start_cnt, 0);
        check("idle_acc_out",   $signed(acc_out), 0);
        check("idle_term_cnt",  term_cnt, 0);
        check("idle_mul_x",     mul_x, 0);

        // 2. Single product, last on first term
        send_pair("t2", 3, -5, 1'b1);
        check("t2_mul_x", $signed(mul_x), 3);
        check("t2_mul_y", $signed(mul_y), -5);
        check("t2_not_ready", in_ready, 0);
        wait_acc_valid("t2");
        check("t2_starts", start_cnt, 1);
        check("t2_acc_out", $signed(acc_out), -15);
        check("t2_term_cnt", term_cnt, 1);
        drain("t2");

        // 3. Three-term dot product, held output
        send_pair("t3a", 1, 2, 1'b0);
        send_pair("t3b", 3, 4, 1'b0);
        send_pair("t3c", 5, 6, 1'b1);
        wait_acc_valid("t3");
        check("t3_acc_out", $signed(acc_out), 44);
        check("t3_term_cnt", term_cnt, 3);
        tick(5);
        check("t3_held_valid", acc_valid, 1);
        check("t3_held_acc", $signed(acc_out), 44);
        check("t3_held_not_ready", in_ready, 0);
        drain("t3");

        // 4a. 16 maximal products: 2^34, fits in the guarded accumulator
        for (int i = 0; i < 16; i++) send_pair("t4a", -32768, -32768, (i == 15));
        wait_acc_valid("t4a");
        check("t4a_acc_out", $signed(acc_out), 64'sd17179869184);
        check("t4a_term_cnt", term_cnt, 16);
`ifdef SATURATE_EN
        check("t4a_sat_flag", sat_flag, 0);
`endif
        drain("t4a");

        // 4b. 32 maximal products: 2^35 overflows, term_cnt wraps to 0
        for (int i = 0; i < 32; i++) send_pair("t4b", -32768, -32768, (i == 31));
        wait_acc_valid("t4b");
`ifdef SATURATE_EN
        check("t4b_acc_clamp", $signed(acc_out), 64'sd34359738367);
        check("t4b_sat_flag", sat_flag, 1);
`else
        check("t4b_acc_wrap", $signed(acc_out), -64'sd34359738368);
`endif
        check("t4b_term_wrap", term_cnt, 0);
        drain("t4b");
`ifdef SATURATE_EN
        check("t4b_sat_clear", sat_flag, 0);
`endif

        // 5. in_valid held while the previous pair is in flight
        s0 = start_cnt;
        send_pair("t5a", 10, 10, 1'b0);
        in_valid = 1'b1; in_x = 16'd1; in_y = 16'd1; in_last = 1'b1;
        for (int i = 0; i < 50 && !mul_busy; i++) tick(1);
        check("t5_busy_seen", mul_busy, 1);
        check("t5_wait_lo_not_ready", in_ready, 0);
        check("t5_mul_x_held", mul_x, 10);
        check("t5_one_start", start_cnt - s0, 1);
        send_pair("t5b", 1, 1, 1'b1);
        wait_acc_valid("t5");
        check("t5_acc_out", $signed(acc_out), 101);
        check("t5_term_cnt", term_cnt, 2);
        check("t5_starts", start_cnt - s0, 2);
        drain("t5");

        // 6. Reset during WAIT_LO discards partial sum and in-flight product
        send_pair("t6a", 7, 7, 1'b0);
        send_pair("t6b", 9, 9, 1'b0);
        for (int i = 0; i < 50 && !mul_busy; i++) tick(1);
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t6_rst_ready", in_ready, 1);
        check("t6_rst_acc", $signed(acc_out), 0);
        send_pair("t6c", 2, 2, 1'b1);
        wait_acc_valid("t6");
        check("t6_acc_out", $signed(acc_out), 4);
        check("t6_term_cnt", term_cnt, 1);
        drain("t6");

        check("start_single_cycle", start_run_err, 0);
        check("operands_held_busy", hold_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
